// File: rtl/fetch_pkg.sv
// Shared widths, the fetch word size and the buffered-instruction record
// used by the fetch stage and its instruction FIFO.
package fetch_pkg;

   localparam int FETCH_WORD_BYTES = 4;
   localparam int XLEN             = 32;
   localparam int ILEN             = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] data;
   } fifo_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flop-based FIFO: head is read straight from storage registers, push lands next cycle.
// No internal backpressure: caller must not push when full unless it pops; flush beats push.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q;
   logic [PW-1:0]    wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same edge, so push-while-full is fine then.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign count = cnt_q;
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch: credit-limited word reads, responses buffered with PCs; response->instr_valid 1 cycle.
// Requests stop once buffered + outstanding reaches DEPTH; redirect flushes and drops in-flight words.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] ENTRY_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int            CW      = $clog2(DEPTH+1);
   localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
   logic [CW-1:0]   outst_q,    outst_d;
   logic [CW-1:0]   drop_q,     drop_d;

   logic            req_fire;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fifo_entry_t     fifo_head;
   fifo_entry_t     push_entry;

   assign mem_req_valid = !rst && (({1'b0, fifo_count} + {1'b0, outst_q}) < CREDITS);
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;

   assign instr_valid   = !fifo_empty;
   assign instr_data    = instr_valid ? fifo_head.data : '0;
   assign instr_pc      = instr_valid ? fifo_head.pc   : '0;
   assign fifo_pop      = instr_valid && instr_ready;

   assign outst_d       = outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
   assign push_entry    = '{pc: rsp_pc_q, data: mem_rsp_data};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      fifo_push  = 1'b0;
      if (redirect_valid) begin
         // Everything still in flight after this edge belongs to the old path.
         fetch_pc_d = word_align(redirect_pc);
         rsp_pc_d   = word_align(redirect_pc);
         drop_d     = outst_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(FETCH_WORD_BYTES);
         end
         if (mem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               fifo_push = 1'b1;
               rsp_pc_d  = rsp_pc_q + XLEN'(FETCH_WORD_BYTES);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= ENTRY_ADDR;
         rsp_pc_q   <= ENTRY_ADDR;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(mem_rsp_valid && outst_q == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for streaming/backpressure, scoreboard of accepted
// request addresses against delivered PCs/data, and hand sequences for redirect and reset.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   instr_fetch_unit #(.DEPTH(DEPTH), .ENTRY_ADDR(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mem_lat = 1;
   int cyc = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] sb_e;
   logic        fire_s = 1'b0;
   logic [31:0] addr_s = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: accepted requests on the current path must come back out in order.
   always @(negedge clk) begin
      fire_s = 1'b0;
      if (!rst) begin
         if (dut.fifo_full) begin
            checks++;
            if (dut.fifo_push) begin
               errors++;
               $display("FAIL push_when_full: push=1 with full=1 at pc %h", dut.rsp_pc_q);
            end
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got pc %h want no instruction", instr_pc);
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_pc", instr_pc, sb_e);
               check("sb_data", instr_data, sb_e ^ KEY);
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
         end else if (mem_req_valid && mem_req_ready) begin
            exp_q.push_back(mem_req_addr);
         end
         fire_s = mem_req_valid && mem_req_ready;
         addr_s = mem_req_addr;
      end
   end

   // In-order memory with fixed latency mem_lat, reset together with the DUT.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            mq.delete();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
         end else begin
            if (fire_s) mq.push_back('{addr: addr_s, due: cyc - 1 + mem_lat});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = mq[0].addr ^ KEY;
               void'(mq.pop_front());
            end else begin
               mem_rsp_valid = 1'b0;
               mem_rsp_data  = '0;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_first(input string name, input logic [31:0] exp_pc);
      bit seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (instr_valid) begin
            seen = 1'b1;
            check(name, instr_pc, exp_pc);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no instr_valid within 30 cycles, want pc %h", name, exp_pc);
      end
   endtask

   typedef struct {
      bit          rst_first;
      bit          ir;
      bit          mr;
      bit          e_rv;
      logic [31:0] e_addr;
      bit          e_iv;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      instr_ready    = 1'b0;
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Streaming with one-cycle memory, then backpressure and release.
      vt[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
      vt[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
      vt[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h00};
      vt[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h04};
      vt[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h08};
      vt[5]  = '{1, 0, 1, 1, 32'h00, 0, 32'h00};
      vt[6]  = '{0, 0, 1, 1, 32'h04, 0, 32'h00};
      vt[7]  = '{0, 0, 1, 1, 32'h08, 1, 32'h00};
      vt[8]  = '{0, 0, 1, 1, 32'h0C, 1, 32'h00};
      vt[9]  = '{0, 0, 1, 0, 32'h10, 1, 32'h00};
      vt[10] = '{0, 0, 1, 0, 32'h10, 1, 32'h00};
      vt[11] = '{0, 1, 1, 0, 32'h10, 1, 32'h00};
      vt[12] = '{0, 1, 1, 1, 32'h10, 1, 32'h04};
      vt[13] = '{0, 1, 1, 1, 32'h14, 1, 32'h08};
      vt[14] = '{0, 1, 1, 1, 32'h18, 1, 32'h0C};
      vt[15] = '{0, 1, 1, 1, 32'h1C, 1, 32'h10};

      for (int i = 0; i < 16; i++) begin
         if (vt[i].rst_first) begin
            mem_lat       = 1;
            instr_ready   = vt[i].ir;
            mem_req_ready = vt[i].mr;
            do_reset();
         end else begin
            step();
            instr_ready   = vt[i].ir;
            mem_req_ready = vt[i].mr;
         end
         @(negedge clk);
         check($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid), 32'(vt[i].e_rv));
         check($sformatf("vec%0d_req_addr", i), mem_req_addr, vt[i].e_addr);
         check($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
         if (vt[i].e_iv) check($sformatf("vec%0d_instr_pc", i), instr_pc, vt[i].e_pc);
      end

      // Redirect with two requests in flight on a 3-cycle memory.
      mem_lat = 3; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      step();
      step();
      mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      redirect_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      check("inflight_drop", 32'(dut.drop_q), 32'd2);
      check("inflight_addr", mem_req_addr, 32'h100);
      check("inflight_flushed", 32'(instr_valid), 32'd0);
      wait_first("inflight_first_pc", 32'h100);

      // Redirect coinciding with a request fire and a response.
      mem_lat = 2; instr_ready = 1'b1; mem_req_ready = 1'b1;
      do_reset();
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      check("simul_rsp_present", 32'(mem_rsp_valid && mem_req_valid), 32'd1);
      check("simul_prior_outst", 32'(dut.outst_q), 32'd2);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("simul_drop", 32'(dut.drop_q), 32'd2);
      check("simul_flushed", 32'(instr_valid), 32'd0);
      check("simul_addr", mem_req_addr, 32'h200);
      wait_first("simul_first_pc", 32'h200);

      // Memory stalled, then redirected while stalled.
      mem_lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_addr", k), mem_req_addr, 32'h0);
      end
      check("stall_valid", 32'(mem_req_valid), 32'd1);
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("stall_redirect_addr", mem_req_addr, 32'h40);
      step();
      mem_req_ready = 1'b1;
      wait_first("stall_first_pc", 32'h40);

      // Asynchronous reset mid-stream with the buffer half full.
      mem_lat = 1; instr_ready = 1'b0; mem_req_ready = 1'b1;
      do_reset();
      step();
      step();
      step();
      @(negedge clk);
      check("areset_pre_count", 32'(dut.fifo_count), 32'd2);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("areset_instr_valid", 32'(instr_valid), 32'd0);
      check("areset_req_valid", 32'(mem_req_valid), 32'd0);
      check("areset_instr_pc", instr_pc, 32'h0);
      check("areset_instr_data", instr_data, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      check("areset_restart_addr", mem_req_addr, 32'h0);
      check("areset_restart_valid", 32'(mem_req_valid), 32'd1);
      wait_first("areset_first_pc", 32'h0);

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Decoupled instruction fetch stage that sits directly upstream of the nano-cpu core's decode/execute. It issues word reads to a memory port with a valid/ready request and in-order response, and buffers fetched words with their PCs in a small FIFO. It hands instructions to the core through a valid/ready handshake. A redirect (taken branch/jump) flushes the buffer and discards in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the maximum number of outstanding requests (power of 2, at least 2).
ENTRY_ADDR, 32'h0, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  reset
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  word address, bits [1:0] always 0
mem_rsp_valid  in  1  response valid; in order; no backpressure
mem_rsp_data  in  32  response word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  core consumes head
instr_data  out  32  instruction word at head
instr_pc  out  32  PC of head
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. While rst is high and on release:
  - fetch_pc = ENTRY_ADDR; FIFO empty; outstanding = 0; drop = 0.
  - mem_req_valid = 0 (gated by rst); instr_valid = 0; instr_data = 0; instr_pc = 0.
- Handshake events:
  - req_fire = mem_req_valid && mem_req_ready.
  - pop = instr_valid && instr_ready.
- Request issue:
  - mem_req_valid = !rst && (occupancy + outstanding < DEPTH), so credits never overflow the FIFO.
  - mem_req_addr = fetch_pc.
  - On req_fire: fetch_pc += 4 (wraps at 2^32), outstanding++.
  - addr and valid stay stable while not accepted, except in the cycle after a redirect.
- Response handling:
  - On mem_rsp_valid: outstanding--.
  - If drop > 0: drop--, word discarded.
  - Else push {rsp_pc, mem_rsp_data}. rsp_pc is a register set on redirect and reset, and incremented by 4 on every accepted (non-dropped) push.
- Latency:
  - Response in cycle N is visible on instr_valid/instr_data in cycle N+1. There is no bypass.
  - With mem_req_ready = 1, one-cycle memory and instr_ready = 1, the first instr_valid occurs 2 cycles after reset release.
  - Sustained throughput is 1 instruction/cycle when memory latency + 1 <= DEPTH.
- Occupancy:
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - Push never occurs when full, guaranteed by the credit rule; the bench asserts this.
- Redirect (highest priority; takes effect at the clock edge):
  - FIFO cleared; next cycle instr_valid = 0.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop = outstanding + req_fire - mem_rsp_valid, i.e. every request still in flight after this cycle, including one accepted in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle counts as consumed.
  - A redirect while drop > 0 recomputes drop by the same formula.
- Counters: occupancy, outstanding and drop are $clog2(DEPTH+1) bits. outstanding decrementing below 0 (an unsolicited response) is an assertion error.
- Reset mid-operation: all state clears immediately. The memory port is reset by the same rst, so no stale responses arrive.

Decomposition:
- Package fetch_pkg: FETCH_WORD_BYTES = 4, instruction/address width localparams, and the fifo entry struct {pc[31:0], data[31:0]}.
- One sub-module: sync_fifo (WIDTH = 64, DEPTH).
  - Async active-high reset.
  - Ports: push, pop, flush, full, empty, count, head.
  - Registered output; flush has priority over push.
- Credit, drop and PC logic stay in instr_fetch_unit.

Test Plan:
- Baseline streaming:
  - Stimulus: ENTRY_ADDR = 0; mem_req_ready = 1; one-cycle memory returning data = addr ^ 32'hA5A5_0000; instr_ready = 1.
  - Required: mem_req_addr 0x0, 0x4, 0x8, ...; instr_pc and data match one per cycle from cycle 2.
- Backpressure:
  - Stimulus: instr_ready = 0.
  - Required: exactly 4 requests (0x0–0xC), then mem_req_valid = 0 with occupancy 4.
  - Stimulus: raise instr_ready.
  - Required: pops at 0x0, next request at 0x10, no loss or duplication.
- Redirect with in-flight data:
  - Stimulus: 3-cycle memory latency; redirect_pc = 0x103 asserted with 2 outstanding.
  - Required: both stale responses dropped; next instr_pc = 0x100; next mem_req_addr = 0x100.
- Simultaneous events:
  - Stimulus: redirect_valid in the same cycle as req_fire and mem_rsp_valid.
  - Required: the response is discarded; drop = prior outstanding; the first delivered instr_pc equals the redirect target.
- Stalled memory:
  - Stimulus: mem_req_ready = 0.
  - Required: mem_req_addr holds 0x0 for 10 cycles.
  - Stimulus: redirect to 0x40.
  - Required: addr = 0x40 next cycle; after ready rises, the first instr_pc = 0x40.
- Async reset:
  - Stimulus: rst pulsed mid-stream, off-edge, with the FIFO half full.
  - Required: instr_valid and mem_req_valid go 0 immediately; after release, fetch restarts at ENTRY_ADDR.
